// File: rtl/icache_pkg.sv
// Shared types for the I-cache data array: refill FSM state encoding and
// a slice-offset helper used to address beats inside a line and lines
// inside the packed multi-way read bus.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } refill_state_t;

    // Bit offset of slice idx within a vector built from width-bit slices.
    function automatic int unsigned slice_lsb(input int unsigned idx,
                                              input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/icache_data_way.sv
// One way of the I-cache data array: simple dual-port RAM, 1 write + 1 read port.
// Latency: 1 cycle read; a same-address read/write returns the OLD contents.
// Backpressure: none, both ports accept every cycle.
// Ports: clk/rst (rst clears only the read register), we/waddr/wdata write port,
//        re/raddr read port, rdata registered read data (held while re=0).
module icache_data_way #(
    parameter int ADDR_WIDTH = 4,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [LINE_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [LINE_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [LINE_WIDTH-1:0] mem [0:DEPTH-1];

    // Storage carries no reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register samples mem before this edge's write lands, which gives
    // read-old-data on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/icache_data_array.sv
// N-way I-cache data array with line-refill engine (beats -> line buffer -> one-cycle write).
// Latency: reads 1 cycle (rd_line combinational from rd_hit); refill commits 1 cycle after last beat.
// Backpressure: beat_ready high only in FILL; refill_start accepted only when idle, never queued.
// Ports: rd_valid/rd_addr/rd_hit -> rd_lines/rd_line/rd_data_valid (read side);
//        refill_start/refill_addr/refill_way, beat_valid/beat_data/beat_ready,
//        refill_busy/refill_done (refill side). Sync active-high rst.
// Option: define ICACHE_DATA_FWD_EN to forward the line being written to a same-set read
//         sampled in the WRITE cycle; otherwise that read returns old data.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int LINE_WIDTH = 128,
    parameter int BEAT_WIDTH = 32,
    parameter int WAYS       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_valid,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    input  logic [WAYS-1:0]            rd_hit,
    output logic [WAYS*LINE_WIDTH-1:0] rd_lines,
    output logic [LINE_WIDTH-1:0]      rd_line,
    output logic                       rd_data_valid,
    input  logic                       refill_start,
    input  logic [ADDR_WIDTH-1:0]      refill_addr,
    input  logic [WAYS-1:0]            refill_way,
    input  logic                       beat_valid,
    input  logic [BEAT_WIDTH-1:0]      beat_data,
    output logic                       beat_ready,
    output logic                       refill_busy,
    output logic                       refill_done
);

    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    refill_state_t             state;
    refill_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0]     fill_addr;
    logic [WAYS-1:0]           fill_way;
    logic [BEAT_CNT_W-1:0]     beat_cnt;
    logic [LINE_WIDTH-1:0]     line_buf;
    logic                      start_acc;
    logic                      beat_fire;
    logic                      last_beat;
    logic [WAYS-1:0]           way_we;
    logic [WAYS*LINE_WIDTH-1:0] ram_lines;

    assign last_beat = (beat_cnt == BEAT_CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_acc   = 1'b0;
        beat_fire   = 1'b0;
        beat_ready  = 1'b0;
        refill_busy = 1'b0;
        refill_done = 1'b0;
        way_we      = '0;
        case (state)
            IDLE: begin
                if (refill_start) begin
                    start_acc = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                beat_ready  = 1'b1;
                refill_busy = 1'b1;
                beat_fire   = beat_valid;
                if (beat_valid && last_beat) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                refill_busy = 1'b1;
                refill_done = 1'b1;
                // A zero way mask still completes the refill, it just writes nothing.
                way_we      = fill_way;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Refill target latch, beat counter and line assembly buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_addr <= '0;
            fill_way  <= '0;
            beat_cnt  <= '0;
            line_buf  <= '0;
        end else begin
            if (start_acc) begin
                fill_addr <= refill_addr;
                fill_way  <= refill_way;
                beat_cnt  <= '0;
            end
            if (beat_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
                for (int b = 0; b < BEATS; b++) begin
                    if (beat_cnt == BEAT_CNT_W'(b)) begin
                        line_buf[slice_lsb(b, BEAT_WIDTH) +: BEAT_WIDTH] <= beat_data;
                    end
                end
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_data_way #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .LINE_WIDTH (LINE_WIDTH)
        ) u_way (
            .clk   (clk),
            .rst   (rst),
            .we    (way_we[w]),
            .waddr (fill_addr),
            .wdata (line_buf),
            .re    (rd_valid),
            .raddr (rd_addr),
            .rdata (ram_lines[w*LINE_WIDTH +: LINE_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_valid;
        end
    end

`ifdef ICACHE_DATA_FWD_EN
    // Capture which ways a read collided with the commit, plus the committed
    // line; both only move on rd_valid so rd_lines keeps holding between reads.
    logic [WAYS-1:0]       fwd_sel;
    logic [LINE_WIDTH-1:0] fwd_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_sel  <= '0;
            fwd_line <= '0;
        end else if (rd_valid) begin
            fwd_sel  <= (state == WRITE && rd_addr == fill_addr) ? fill_way : '0;
            fwd_line <= line_buf;
        end
    end

    always_comb begin
        rd_lines = ram_lines;
        for (int w = 0; w < WAYS; w++) begin
            if (fwd_sel[w]) begin
                rd_lines[slice_lsb(w, LINE_WIDTH) +: LINE_WIDTH] = fwd_line;
            end
        end
    end
`else
    assign rd_lines = ram_lines;
`endif

    // Hit-way mux; an all-zero hit vector yields zero, multi-hot ORs the ways.
    always_comb begin
        rd_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (rd_hit[w]) begin
                rd_line = rd_line | rd_lines[slice_lsb(w, LINE_WIDTH) +: LINE_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_icache_data_array.sv
module tb_icache_data_array;

    localparam int AW   = 4;
    localparam int LW   = 128;
    localparam int BW   = 32;
    localparam int NW   = 2;
    localparam int NB   = LW / BW;
    localparam int SETS = 16;
    localparam int LW4  = 256;
    localparam int NW4  = 4;
    localparam int NB4  = LW4 / BW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration DUT signals
    logic            rst;
    logic            rd_valid;
    logic [AW-1:0]   rd_addr;
    logic [NW-1:0]   rd_hit;
    logic [NW*LW-1:0] rd_lines;
    logic [LW-1:0]   rd_line;
    logic            rd_data_valid;
    logic            refill_start;
    logic [AW-1:0]   refill_addr;
    logic [NW-1:0]   refill_way;
    logic            beat_valid;
    logic [BW-1:0]   beat_data;
    logic            beat_ready;
    logic            refill_busy;
    logic            refill_done;

    // 4-way, 256-bit DUT signals
    logic              w4_rst;
    logic              w4_rd_valid;
    logic [AW-1:0]     w4_rd_addr;
    logic [NW4-1:0]    w4_rd_hit;
    logic [NW4*LW4-1:0] w4_rd_lines;
    logic [LW4-1:0]    w4_rd_line;
    logic              w4_rd_data_valid;
    logic              w4_refill_start;
    logic [AW-1:0]     w4_refill_addr;
    logic [NW4-1:0]    w4_refill_way;
    logic              w4_beat_valid;
    logic [BW-1:0]     w4_beat_data;
    logic              w4_beat_ready;
    logic              w4_refill_busy;
    logic              w4_refill_done;

    icache_data_array #(
        .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .WAYS(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_hit(rd_hit),
        .rd_lines(rd_lines), .rd_line(rd_line), .rd_data_valid(rd_data_valid),
        .refill_start(refill_start), .refill_addr(refill_addr), .refill_way(refill_way),
        .beat_valid(beat_valid), .beat_data(beat_data), .beat_ready(beat_ready),
        .refill_busy(refill_busy), .refill_done(refill_done)
    );

    icache_data_array #(
        .ADDR_WIDTH(AW), .LINE_WIDTH(LW4), .BEAT_WIDTH(BW), .WAYS(NW4)
    ) dut4 (
        .clk(clk), .rst(w4_rst),
        .rd_valid(w4_rd_valid), .rd_addr(w4_rd_addr), .rd_hit(w4_rd_hit),
        .rd_lines(w4_rd_lines), .rd_line(w4_rd_line), .rd_data_valid(w4_rd_data_valid),
        .refill_start(w4_refill_start), .refill_addr(w4_refill_addr),
        .refill_way(w4_refill_way),
        .beat_valid(w4_beat_valid), .beat_data(w4_beat_data), .beat_ready(w4_beat_ready),
        .refill_busy(w4_refill_busy), .refill_done(w4_refill_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: array contents per way/set, plus the refill in progress
    // described as "collecting beats" or "committing" with a count of beats seen.
    logic [LW-1:0] m_mem [NW][SETS];
    bit            m_known [NW][SETS];
    bit            m_filling, m_writing;
    int            m_got;
    logic [LW-1:0] m_buf;
    logic [AW-1:0] m_addr;
    logic [NW-1:0] m_way;
    logic [LW-1:0] exp_line [NW];
    bit            exp_known [NW];
    bit            exp_dv;
    int            done_cnt, busy_cnt;

    // One clock cycle: entered and left at a negedge. Checks the outputs of the
    // current cycle, drives the inputs for the coming edge, advances the model.
    task automatic cycle(input bit rv, input logic [AW-1:0] ra, input logic [NW-1:0] hit,
                         input bit rs, input logic [AW-1:0] rfa, input logic [NW-1:0] rfw,
                         input bit bv, input logic [BW-1:0] bd);
        logic [LW-1:0] or_line;
        bit            or_known;
        rd_hit = hit;
        #1;
        check("refill_busy", refill_busy, m_filling | m_writing);
        check("beat_ready", beat_ready, m_filling);
        check("refill_done", refill_done, m_writing);
        check("rd_data_valid", rd_data_valid, exp_dv);
        or_line  = '0;
        or_known = 1'b1;
        for (int w = 0; w < NW; w++) begin
            if (exp_known[w]) check("rd_lines", rd_lines[w*LW +: LW], exp_line[w]);
            if (hit[w]) begin
                or_line  = or_line | exp_line[w];
                or_known = or_known & exp_known[w];
            end
        end
        if (or_known) check("rd_line", rd_line, or_line);
        if (refill_done) done_cnt++;
        if (refill_busy) busy_cnt++;

        rd_valid = rv; rd_addr = ra;
        refill_start = rs; refill_addr = rfa; refill_way = rfw;
        beat_valid = bv; beat_data = bd;

        if (rv) begin
            exp_dv = 1'b1;
            for (int w = 0; w < NW; w++) begin
                exp_line[w]  = m_mem[w][ra];
                exp_known[w] = m_known[w][ra];
`ifdef ICACHE_DATA_FWD_EN
                if (m_writing && ra == m_addr && m_way[w]) begin
                    exp_line[w]  = m_buf;
                    exp_known[w] = 1'b1;
                end
`endif
            end
        end else begin
            exp_dv = 1'b0;
        end
        if (m_writing) begin
            for (int w = 0; w < NW; w++) begin
                if (m_way[w]) begin
                    m_mem[w][m_addr]   = m_buf;
                    m_known[w][m_addr] = 1'b1;
                end
            end
            m_writing = 1'b0;
        end else if (m_filling) begin
            if (bv) begin
                m_buf[m_got*BW +: BW] = bd;
                m_got++;
                if (m_got == NB) begin
                    m_filling = 1'b0;
                    m_writing = 1'b1;
                end
            end
        end else if (rs) begin
            m_filling = 1'b1;
            m_got     = 0;
            m_addr    = rfa;
            m_way     = rfw;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [NW-1:0] hit);
        cycle(1'b0, '0, hit, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cycle(1'b1, a, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_valid = 1'b0; refill_start = 1'b0; beat_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_filling = 1'b0;
        m_writing = 1'b0;
        exp_dv    = 1'b0;
        for (int w = 0; w < NW; w++) begin
            exp_line[w]  = '0;
            exp_known[w] = 1'b1;
        end
    endtask

    // Start + all beats; gap idle cycles before each beat; optionally keep
    // hammering refill_start (to another set/way) throughout. Returns in WRITE.
    task automatic refill(input logic [AW-1:0] a, input logic [NW-1:0] way,
                          input logic [LW-1:0] line, input int gap, input bit restart);
        cycle(1'b0, '0, '0, 1'b1, a, way, 1'b0, '0);
        for (int b = 0; b < NB; b++) begin
            for (int g = 0; g < gap; g++)
                cycle(1'b0, '0, '0, restart, a ^ 4'h1, ~way, 1'b0, 32'hDEADBEEF);
            cycle(1'b0, '0, '0, restart, a ^ 4'h1, ~way, 1'b1, line[b*BW +: BW]);
        end
    endtask

    logic [LW-1:0]  l1, l2, l3, l4, l5;
    logic [LW4-1:0] lines4 [NW4];
    int             t;

    initial begin
        rst = 1'b1; rd_valid = 1'b0; rd_addr = '0; rd_hit = '0;
        refill_start = 1'b0; refill_addr = '0; refill_way = '0;
        beat_valid = 1'b0; beat_data = '0;
        w4_rst = 1'b1; w4_rd_valid = 1'b0; w4_rd_addr = '0; w4_rd_hit = '0;
        w4_refill_start = 1'b0; w4_refill_addr = '0; w4_refill_way = '0;
        w4_beat_valid = 1'b0; w4_beat_data = '0;
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < SETS; s++) m_known[w][s] = 1'b0;
        done_cnt = 0; busy_cnt = 0; m_got = 0; m_buf = '0; m_addr = '0; m_way = '0;

        l1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        l2 = {$urandom, $urandom, $urandom, $urandom};
        l3 = {$urandom, $urandom, $urandom, $urandom};
        l4 = {$urandom, $urandom, $urandom, $urandom};
        l5 = {$urandom, $urandom, $urandom, $urandom};

        // 1: reset state, basic refill of set 3 way 1, read back
        do_reset();
        idle('0);
        check("reset_rd_lines", rd_lines, '0);
        done_cnt = 0;
        refill(4'd3, 2'b10, l1, 0, 1'b0);
        idle('0);
        rd(4'd3);
        idle(2'b10);
        check("t1_rd_line", rd_line, l1);
        idle('0);
        check("t1_done_pulses", done_cnt, 1);

        // 2: gapped beats, busy length
        busy_cnt = 0;
        refill(4'd7, 2'b01, l2, 2, 1'b0);
        idle('0);
        idle('0);
        check("t2_busy_cycles", busy_cnt, NB * 3 + 1);
        rd(4'd7);
        idle(2'b01);
        check("t2_rd_line", rd_line, l2);

        // 3: refill_start / beat_valid while busy or idle are ignored; multi-hot way
        done_cnt = 0;
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 32'hBAD0BAD0);
        refill(4'd9, 2'b11, l3, 1, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 4'd2, 2'b01, 1'b1, 32'hBAD1BAD1);
        idle('0);
        idle('0);
        check("t3_done_pulses", done_cnt, 1);
        rd(4'd9);
        idle(2'b01);
        check("t3_way0", rd_line, l3);
        idle(2'b10);
        check("t3_way1", rd_line, l3);

        // 4: read colliding with the commit; other set unaffected
        refill(4'd5, 2'b10, l5, 0, 1'b0);
        idle('0);
        refill(4'd3, 2'b10, l4, 0, 1'b0);
        rd(4'd3);
        idle(2'b10);
`ifdef ICACHE_DATA_FWD_EN
        check("t4_collision", rd_line, l4);
`else
        check("t4_collision", rd_line, l1);
`endif
        rd(4'd5);
        idle(2'b10);
        check("t4_other_set", rd_line, l5);
        rd(4'd3);
        idle(2'b10);
        check("t4_after_write", rd_line, l4);

        // 5: reset mid-refill aborts without writing
        cycle(1'b0, '0, '0, 1'b1, 4'd3, 2'b10, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 32'hAAAA0000);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 32'hAAAA0001);
        do_reset();
        check("t5_busy", refill_busy, 1'b0);
        check("t5_ready", beat_ready, 1'b0);
        idle('0);
        rd(4'd3);
        idle(2'b10);
        check("t5_no_write", rd_line, l4);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, SETS - 1)),
                  NW'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  AW'($urandom_range(0, SETS - 1)), NW'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), BW'($urandom));
        end
        idle('0);

        // 6: 4-way, 256-bit lines; all ways of set 0
        @(negedge clk);
        w4_rst = 1'b0;
        for (int w = 0; w < NW4; w++) begin
            for (int k = 0; k < NB4; k++) lines4[w][k*BW +: BW] = $urandom;
            w4_refill_start = 1'b1; w4_refill_addr = '0; w4_refill_way = NW4'(1 << w);
            @(negedge clk);
            w4_refill_start = 1'b0;
            for (int b = 0; b < NB4; b++) begin
                w4_beat_valid = 1'b1;
                w4_beat_data  = lines4[w][b*BW +: BW];
                check("t6_ready", w4_beat_ready, 1'b1);
                @(negedge clk);
            end
            w4_beat_valid = 1'b0;
            t = 0;
            while (!w4_refill_done && t < 10) begin
                @(negedge clk);
                t++;
            end
            check("t6_done", w4_refill_done, 1'b1);
            @(negedge clk);
        end
        w4_rd_valid = 1'b1; w4_rd_addr = '0;
        @(negedge clk);
        w4_rd_valid = 1'b0;
        check("t6_rd_data_valid", w4_rd_data_valid, 1'b1);
        for (int w = 0; w < NW4; w++) begin
            w4_rd_hit = NW4'(1 << w);
            #1;
            check("t6_way_line", w4_rd_line, lines4[w]);
        end
        w4_rd_hit = '0;
        #1;
        check("t6_no_hit", w4_rd_line, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
